// File: rtl/collision_scanner_pkg.sv
// collision_scanner_pkg: shared widths for the collision scanner and its comparator.
package collision_scanner_pkg;
    localparam int CS_POSITION_WIDTH = 8;
    localparam int CS_OBJ_ADDR_WIDTH = 3;
endpackage

// File: rtl/collision_scanner_aabb.sv
// aabb_collision: strict axis-aligned box overlap; touching edges and degenerate boxes never overlap.
module aabb_collision
    import collision_scanner_pkg::*;
#(
    parameter int W = CS_POSITION_WIDTH
) (
    input  logic [W-1:0] i_a_x1,
    input  logic [W-1:0] i_a_y1,
    input  logic [W-1:0] i_a_x2,
    input  logic [W-1:0] i_a_y2,
    input  logic [W-1:0] i_b_x1,
    input  logic [W-1:0] i_b_y1,
    input  logic [W-1:0] i_b_x2,
    input  logic [W-1:0] i_b_y2,
    output logic         o_overlap
);
    logic w_valid_boxes;
    assign w_valid_boxes = (i_a_x1 < i_a_x2) && (i_a_y1 < i_a_y2) && (i_b_x1 < i_b_x2) && (i_b_y1 < i_b_y2);
    assign o_overlap = w_valid_boxes && (i_a_x1 < i_b_x2) && (i_a_x2 > i_b_x1) && (i_a_y1 < i_b_y2) && (i_a_y2 > i_b_y1);
endmodule

// File: rtl/collision_scanner.sv
// collision_scanner: walks the object table once per start, testing every pair i<j for overlap
// and publishing a hit stream plus a double-buffered per-object collision mask.
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int NUM_OBJECTS    = 8,
    parameter int POSITION_WIDTH = CS_POSITION_WIDTH,
    parameter int ADDR_WIDTH     = CS_OBJ_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    output logic [ADDR_WIDTH-1:0]     obj_addr,
    input  logic                      obj_active,
    input  logic [POSITION_WIDTH-1:0] obj_x1,
    input  logic [POSITION_WIDTH-1:0] obj_y1,
    input  logic [POSITION_WIDTH-1:0] obj_x2,
    input  logic [POSITION_WIDTH-1:0] obj_y2,
    output logic                      busy,
    output logic                      done,
    output logic                      hit_valid,
    output logic [ADDR_WIDTH-1:0]     hit_a,
    output logic [ADDR_WIDTH-1:0]     hit_b,
    output logic [NUM_OBJECTS-1:0]    collision_mask
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH_I = 3'd1;
    localparam logic [2:0] LATCH_I = 3'd2;
    localparam logic [2:0] SCAN    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(NUM_OBJECTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(NUM_OBJECTS - 2);

    logic [2:0]                r_state;
    logic [ADDR_WIDTH-1:0]     r_i;
    logic [ADDR_WIDTH-1:0]     r_j;
    logic [POSITION_WIDTH-1:0] r_x1;
    logic [POSITION_WIDTH-1:0] r_y1;
    logic [POSITION_WIDTH-1:0] r_x2;
    logic [POSITION_WIDTH-1:0] r_y2;
    logic                      r_act_i;
    logic [NUM_OBJECTS-1:0]    r_work;
    logic [NUM_OBJECTS-1:0]    r_mask;
    logic                      r_hit_valid;
    logic [ADDR_WIDTH-1:0]     r_hit_a;
    logic [ADDR_WIDTH-1:0]     r_hit_b;
    logic                      w_overlap;
    logic                      w_hit;
    logic [NUM_OBJECTS-1:0]    w_work_next;

    aabb_collision #(.W(POSITION_WIDTH)) u_aabb (
        .i_a_x1(r_x1), .i_a_y1(r_y1), .i_a_x2(r_x2), .i_a_y2(r_y2),
        .i_b_x1(obj_x1), .i_b_y1(obj_y1), .i_b_x2(obj_x2), .i_b_y2(obj_y2),
        .o_overlap(w_overlap)
    );

    assign w_hit       = (r_state == SCAN) && w_overlap && r_act_i && obj_active;
    // The final pair's hit lands here so the published mask already contains it.
    assign w_work_next = w_hit ? (r_work | (NUM_OBJECTS'(1) << r_i) | (NUM_OBJECTS'(1) << r_j)) : r_work;

    always_comb begin
        obj_addr = (r_state == FETCH_I) ? r_i :
                   (r_state == LATCH_I) ? r_i + 1'b1 :
                   (r_state == SCAN && r_j != LAST) ? r_j + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            r_act_i     <= 1'b0;
            r_work      <= '0;
            r_mask      <= '0;
            r_hit_valid <= 1'b0;
            r_hit_a     <= '0;
            r_hit_b     <= '0;
        end else begin
            r_hit_valid <= w_hit;
            if (w_hit) begin
                r_hit_a <= r_i;
                r_hit_b <= r_j;
            end
            case (r_state)
                IDLE: if (start) begin
                    r_work  <= '0;
                    r_i     <= '0;
                    r_state <= (NUM_OBJECTS == 1) ? DONE : FETCH_I;
                    if (NUM_OBJECTS == 1) r_mask <= '0;
                end
                FETCH_I: r_state <= LATCH_I;
                LATCH_I: begin
                    r_x1    <= obj_x1;
                    r_y1    <= obj_y1;
                    r_x2    <= obj_x2;
                    r_y2    <= obj_y2;
                    r_act_i <= obj_active;
                    r_j     <= r_i + 1'b1;
                    r_state <= SCAN;
                end
                SCAN: begin
                    r_work <= w_work_next;
                    if (r_j == LAST) begin
                        if (r_i == LAST_I) begin
                            r_state <= DONE;
                            r_mask  <= w_work_next;
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= FETCH_I;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign hit_valid      = r_hit_valid;
    assign hit_a          = r_hit_a;
    assign hit_b          = r_hit_b;
    assign collision_mask = r_mask;
endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed scans against a behavioural object table with 1-cycle read latency.
module tb_collision_scanner;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] obj_addr;
    logic       obj_active;
    logic [7:0] obj_x1, obj_y1, obj_x2, obj_y2;
    logic       busy, done, hit_valid;
    logic [2:0] hit_a, hit_b;
    logic [7:0] collision_mask;

    logic       t_act [8];
    logic [7:0] t_x1 [8];
    logic [7:0] t_y1 [8];
    logic [7:0] t_x2 [8];
    logic [7:0] t_y2 [8];

    int checks = 0;
    int passed = 0;
    logic [7:0] prev_mask = 8'h00;

    collision_scanner dut (
        .clk(clk), .reset_n(reset_n), .start(start), .obj_addr(obj_addr),
        .obj_active(obj_active), .obj_x1(obj_x1), .obj_y1(obj_y1), .obj_x2(obj_x2), .obj_y2(obj_y2),
        .busy(busy), .done(done), .hit_valid(hit_valid), .hit_a(hit_a), .hit_b(hit_b),
        .collision_mask(collision_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        obj_active <= t_act[obj_addr];
        obj_x1     <= t_x1[obj_addr];
        obj_y1     <= t_y1[obj_addr];
        obj_x2     <= t_x2[obj_addr];
        obj_y2     <= t_y2[obj_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Inactive entries get a full-screen box so only the active gate keeps them out.
    task automatic clear_table();
        for (int k = 0; k < 8; k++) begin
            t_act[k] = 1'b0; t_x1[k] = 8'd0; t_y1[k] = 8'd0; t_x2[k] = 8'd255; t_y2[k] = 8'd255;
        end
    endtask

    task automatic set_obj(input int k, input logic a, input int x1, input int y1, input int x2, input int y2);
        t_act[k] = a; t_x1[k] = 8'(x1); t_y1[k] = 8'(y1); t_x2[k] = 8'(x2); t_y2[k] = 8'(y2);
    endtask

    // Every test arranges that the objects in exp_mask pairwise overlap, so the hit stream is all i<j in the mask.
    task automatic scan(input logic [7:0] exp_mask, input int restart_at);
        int ea[$], eb[$];
        int nh;
        nh = 0;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                if (exp_mask[i] && exp_mask[j]) begin ea.push_back(i); eb.push_back(j); end
        start = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            chk($sformatf("done@%0d", c), 32'(done), 32'(c == 43));
            chk($sformatf("busy@%0d", c), 32'(busy), 32'(c <= 43));
            if (hit_valid) begin
                if (nh < ea.size()) begin
                    chk($sformatf("hit_a#%0d", nh), 32'(hit_a), 32'(ea[nh]));
                    chk($sformatf("hit_b#%0d", nh), 32'(hit_b), 32'(eb[nh]));
                end
                nh++;
            end
            if (c == 20 || c == 42) chk($sformatf("mask_hold@%0d", c), 32'(collision_mask), 32'(prev_mask));
            if (c >= 43) chk($sformatf("mask_new@%0d", c), 32'(collision_mask), 32'(exp_mask));
        end
        chk("hit_count", 32'(nh), 32'(ea.size()));
        prev_mask = exp_mask;
    endtask

    initial begin
        clear_table();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_hit", 32'(hit_valid), 32'd0);
            chk("idle_mask", 32'(collision_mask), 32'h00);
        end
        set_obj(0, 1, 10, 10, 20, 20);
        set_obj(3, 1, 15, 15, 25, 25);
        scan(8'h09, -1);
        scan(8'h09, 20);
        scan(8'h09, 43);
        clear_table();
        set_obj(1, 1, 0, 0, 10, 10);
        set_obj(2, 1, 10, 0, 20, 10);
        scan(8'h00, -1);
        set_obj(2, 1, 9, 0, 20, 10);
        scan(8'h06, -1);
        for (int k = 0; k < 8; k++) set_obj(k, 1, 0, 0, 5, 5);
        scan(8'hFF, -1);
        t_act[5] = 1'b0;
        scan(8'hDF, -1);
        clear_table();
        set_obj(0, 1, 5, 0, 5, 10);
        set_obj(1, 1, 0, 0, 10, 10);
        scan(8'h00, -1);
        set_obj(0, 1, 10, 10, 20, 20);
        set_obj(1, 0, 0, 0, 255, 255);
        set_obj(3, 1, 15, 15, 25, 25);
        scan(8'h09, -1);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mask", 32'(collision_mask), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hit", 32'(hit_valid), 32'd0);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        prev_mask = 8'h00;
        scan(8'h09, -1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Sequential per-frame collision engine. Walks the object table once per start pulse (typically vblank) and tests every unordered pair (i<j) with the strict AABB overlap rule.
- Emits a per-pair hit stream and a double-buffered per-object collision mask for game logic.
- Sits between the object/sprite attribute table (it is the table's reader) and gameplay logic.

Parameters:
- NUM_OBJECTS, 8, number of table entries scanned. Legal values are ≥1.
- POSITION_WIDTH, `POSITION_WIDTH, width of each box coordinate.
- ADDR_WIDTH, 3, object index width. Must satisfy 2^ADDR_WIDTH ≥ NUM_OBJECTS.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a scan. Accepted only in IDLE.
- obj_addr  out  ADDR_WIDTH  table read address.
- obj_active  in  1  read data: entry enabled. Valid one cycle after obj_addr.
- obj_x1, obj_y1, obj_x2, obj_y2  in  POSITION_WIDTH each  read data: box corners. Valid one cycle after obj_addr.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle.
- done  out  1  one-cycle pulse; collision_mask updates in the same cycle.
- hit_valid  out  1  one-cycle pulse per overlapping pair.
- hit_a, hit_b  out  ADDR_WIDTH each  pair indices, with hit_a < hit_b. Valid only while hit_valid is high.
- collision_mask  out  NUM_OBJECTS  bit k = object k overlapped at least one other object in the last completed scan.

Behaviour:
- Reset (reset_n=0 at an edge):
  - FSM returns to IDLE.
  - busy, done, hit_valid = 0.
  - obj_addr, hit_a, hit_b = 0.
  - collision_mask and the working mask = 0.
  - Reset mid-scan discards all partial results.
- Overlap rule (unsigned, strict): (a.x1<b.x2) && (a.x2>b.x1) && (a.y1<b.y2) && (a.y2>b.y1), and both entries active.
  - Touching edges do not overlap.
  - Degenerate boxes (x1≥x2 or y1≥y2) never overlap.
- Table read port has a fixed 1-cycle latency.
- FSM states are IDLE, FETCH_I, LATCH_I, SCAN, DONE.
  - IDLE: obj_addr=0. On start=1:
    - clear the working mask;
    - i=0;
    - go to FETCH_I, or directly to DONE if NUM_OBJECTS=1.
  - FETCH_I: drive obj_addr=i. Go to LATCH_I.
  - LATCH_I:
    - capture box i and active_i into holding registers;
    - drive obj_addr=i+1;
    - set j=i+1;
    - go to SCAN.
  - SCAN, one pair per cycle:
    - compare the held box i against the read data for j;
    - drive obj_addr=j+1 when j<NUM_OBJECTS-1;
    - on overlap: hit_valid=1, hit_a=i, hit_b=j, and set working-mask bits i and j;
    - when j=NUM_OBJECTS-1: if i=NUM_OBJECTS-2 go to DONE, else i=i+1 and go to FETCH_I;
    - otherwise j=j+1.
  - DONE: collision_mask ← working mask; done=1; busy=1. Go to IDLE.
- Latency: the start cycle is cycle 0, and done is asserted in cycle 2(N-1)+N(N-1)/2+1.
  - N=8 gives cycle 43.
  - N=1 gives cycle 1.
  - Latency is independent of data and obj_active, so inactive entries still consume their cycles.
- hit_valid registered timing: the pulse appears in the cycle after the compare.
  - The final pair's hit therefore coincides with DONE.
  - The working mask must include that final hit before it is published.
- start while busy is ignored, with no queuing.
- start in the same cycle as done: ignored (the FSM is not yet in IDLE).
- collision_mask is stable between done pulses. It never shows partial results.
- Counters i and j never exceed NUM_OBJECTS-1, with no wrap-around at the 2^ADDR_WIDTH boundary.

Decomposition:
- Shared header: `POSITION_WIDTH (existing) and a new `OBJ_ADDR_WIDTH.
- Sub-module: instantiate the existing aabb_collision comparator for the held-box-vs-read-data check. Gate its overlap output with both active bits outside the comparator.
- FSM state encodings are localparams inside collision_scanner.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 cycles, release, with no start → busy=0, done=0, hit_valid=0, collision_mask=8'h00 indefinitely.
- Single overlap: obj0=(10,10,20,20), obj3=(15,15,25,25), all others inactive; pulse start → exactly one hit_valid with hit_a=0, hit_b=3; done at cycle 43; collision_mask=8'h09.
- Edge touch: obj1=(0,0,10,10), obj2=(10,0,20,10), both active → no hit_valid; mask=8'h00. Then change obj2.x1 to 9 and rescan → hit (1,2); mask=8'h06.
- Inactive gate and full pair stream: all 8 boxes identical (0,0,5,5) and active → 28 hits in order (0,1),(0,2)…(6,7); mask=8'hFF. Clear obj5 active and rescan → 21 hits, none containing 5; mask=8'hDF.
- Busy/restart rules: pulse start again at cycle 20 of a scan → ignored, single done at cycle 43. Pulse start the cycle after done → new scan, second done 43 cycles later. collision_mask is unchanged until each done.
- Reset mid-scan: assert reset_n=0 at cycle 30 after a prior scan left mask=8'h09 → mask=8'h00, busy=0, no done. A fresh start then completes normally in 43 cycles.
